// File: rtl/prog_seq_pkg.sv
// Shared widths, defaults and FSM encoding for the program sequencer.
package prog_seq_pkg;

  localparam int DEPTH          = 16;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int ADDR_W         = 4;
  localparam int DATA_W         = 16;
  localparam int LEN_W          = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } seq_state_e;

endpackage

// File: rtl/prog_sequencer_if.sv
// Program-load and processor handshake bundle for the sequencer.
interface prog_sequencer_if;
  import prog_seq_pkg::*;

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [LEN_W-1:0]  ProgLen;
  logic              Start;
  logic              Stop;
  logic              Done;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Busy;
  logic [ADDR_W-1:0] PC;
  logic              Finished;
  logic              Timeout;

  // Sequencer side
  modport slave (
    input  WrEn, WrAddr, WrData, ProgLen, Start, Stop, Done,
    output DIN, Run, Busy, PC, Finished, Timeout
  );

  // Host / processor side
  modport master (
    output WrEn, WrAddr, WrData, ProgLen, Start, Stop, Done,
    input  DIN, Run, Busy, PC, Finished, Timeout
  );

endinterface

// File: rtl/prog_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] words [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DW-1:0] word_reg;

      always_ff @(posedge Clock) begin
        if (we && (waddr == AW'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  assign rdata = words[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Steps a processor through a stored program: issue, wait for Done, advance or finish.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int DEPTH          = prog_seq_pkg::DEPTH,
  parameter int TIMEOUT_CYCLES = prog_seq_pkg::TIMEOUT_CYCLES
) (
  input  logic             Clock,
  input  logic             Resetn,
  prog_sequencer_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] din_reg;
  logic              run_reg;
  logic              busy_reg;
  logic              finished_reg;
  logic              timeout_reg;
  logic              stop_pend_reg;
  logic [WD_W-1:0]   wdog_reg;
  logic [LEN_W-1:0]  len_reg;

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] first_word;
  logic [LEN_W-1:0]  eff_len;
  logic [WD_W-1:0]   wdog_inc;
  logic              is_last;
  logic              end_req;

  assign mem_we = bus.WrEn && (state_reg == ST_IDLE);

  // Read the word that the next ISSUE will present; in WAIT that is PC+1.
  assign rd_addr = (state_reg == ST_WAIT) ? ADDR_W'(pc_reg + 1'b1) : '0;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_mem (
    .Clock (Clock),
    .we    (mem_we),
    .waddr (bus.WrAddr),
    .wdata (bus.WrData),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // A word-0 write landing on the Start edge must reach the first ISSUE.
  assign first_word = (bus.WrEn && (bus.WrAddr == '0)) ? bus.WrData : rd_data;

  assign eff_len  = (bus.ProgLen > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.ProgLen;
  assign wdog_inc = wdog_reg + 1'b1;
  assign is_last  = ((LEN_W'(pc_reg) + 1'b1) == len_reg);
  assign end_req  = is_last || stop_pend_reg || bus.Stop;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      din_reg       <= '0;
      run_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      finished_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      stop_pend_reg <= 1'b0;
      wdog_reg      <= '0;
      len_reg       <= '0;
    end else begin
      run_reg      <= 1'b0;
      finished_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.Start) begin
            len_reg <= eff_len;
            if (eff_len == '0) begin
              finished_reg <= 1'b1;
            end else begin
              state_reg <= ST_ISSUE;
              pc_reg    <= '0;
              din_reg   <= first_word;
              run_reg   <= 1'b1;
              busy_reg  <= 1'b1;
              wdog_reg  <= '0;
            end
          end
        end

        ST_ISSUE: begin
          state_reg <= ST_WAIT;
          wdog_reg  <= '0;
          if (bus.Stop) stop_pend_reg <= 1'b1;
        end

        ST_WAIT: begin
          if (bus.Done) begin
            if (end_req) begin
              state_reg     <= ST_IDLE;
              busy_reg      <= 1'b0;
              din_reg       <= '0;
              finished_reg  <= 1'b1;
              stop_pend_reg <= 1'b0;
            end else begin
              state_reg <= ST_ISSUE;
              pc_reg    <= ADDR_W'(pc_reg + 1'b1);
              din_reg   <= rd_data;
              run_reg   <= 1'b1;
              wdog_reg  <= '0;
            end
          end else if (wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
            state_reg   <= ST_ERROR;
            busy_reg    <= 1'b0;
            din_reg     <= '0;
            timeout_reg <= 1'b1;
            wdog_reg    <= wdog_inc;
          end else begin
            wdog_reg <= wdog_inc;
            if (bus.Stop) stop_pend_reg <= 1'b1;
          end
        end

        ST_ERROR: begin
          if (bus.Start) begin
            state_reg     <= ST_IDLE;
            timeout_reg   <= 1'b0;
            stop_pend_reg <= 1'b0;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.DIN      = din_reg;
  assign bus.Run      = run_reg;
  assign bus.Busy     = busy_reg;
  assign bus.PC       = pc_reg;
  assign bus.Finished = finished_reg;
  assign bus.Timeout  = timeout_reg;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a hand-driven processor Done model.
module tb_prog_sequencer;

  logic Clock;
  logic Resetn;
  int   n_pass;
  int   n_fail;
  int   n_total;
  int   run_cnt;
  int   fin_cnt;
  int   run_base;
  int   fin_base;

  prog_sequencer_if bus ();

  prog_sequencer dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    run_cnt = 0;
    fin_cnt = 0;
  end

  always @(negedge Clock) begin
    if (bus.Run)      run_cnt <= run_cnt + 1;
    if (bus.Finished) fin_cnt <= fin_cnt + 1;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [15:0] data);
    bus.WrEn   = 1'b1;
    bus.WrAddr = addr;
    bus.WrData = data;
    step();
    bus.WrEn   = 1'b0;
  endtask

  task automatic start_prog(input logic [4:0] len);
    bus.ProgLen = len;
    bus.Start   = 1'b1;
    step();
    bus.Start   = 1'b0;
  endtask

  // Entered in the ISSUE cycle; Done is raised in the delay-th WAIT cycle.
  task automatic exec_instr(input logic [15:0] exp_din, input int delay,
                            input logic [3:0] exp_pc, input bit pulse_stop);
    chk("issue_run",  bus.Run,  1);
    chk("issue_din",  bus.DIN,  exp_din);
    chk("issue_pc",   bus.PC,   exp_pc);
    chk("issue_busy", bus.Busy, 1);
    bus.Done = 1'b0;
    step();
    chk("wait_run", bus.Run, 0);
    for (int i = 1; i <= delay; i++) begin
      bus.Done = (i == delay);
      bus.Stop = pulse_stop && (i == 1);
      step();
      if (i < delay) chk("wait_din_hold", bus.DIN, exp_din);
    end
    bus.Done = 1'b0;
    bus.Stop = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    bus.WrEn = 0; bus.WrAddr = '0; bus.WrData = '0; bus.ProgLen = '0;
    bus.Start = 0; bus.Stop = 0; bus.Done = 0;
    Resetn = 1'b0;
    step(); step();
    Resetn = 1'b1;
    step();
    chk("rst_run",  bus.Run, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_pc",   bus.PC, 0);
    chk("rst_din",  bus.DIN, 0);
    chk("rst_fin",  bus.Finished, 0);
    chk("rst_tmo",  bus.Timeout, 0);

    // Three-word program; word 0 written on the same edge as Start
    write_word(4'd1, 16'h5203);
    write_word(4'd2, 16'h4200);
    run_base = run_cnt; fin_base = fin_cnt;
    bus.WrEn = 1'b1; bus.WrAddr = 4'd0; bus.WrData = 16'h1005;
    start_prog(5'd3);
    bus.WrEn = 1'b0;
    exec_instr(16'h1005, 1, 4'd0, 0);
    exec_instr(16'h5203, 2, 4'd1, 0);
    exec_instr(16'h4200, 3, 4'd2, 0);
    chk("p3_fin",  bus.Finished, 1);
    chk("p3_busy", bus.Busy, 0);
    chk("p3_din",  bus.DIN, 0);
    chk("p3_pc",   bus.PC, 2);
    step();
    chk("p3_fin_pulse", bus.Finished, 0);
    chk("p3_runs", run_cnt - run_base, 3);
    chk("p3_fins", fin_cnt - fin_base, 1);

    // ProgLen beyond DEPTH clamps to 16
    for (int i = 0; i < 16; i++) write_word(4'(i), 16'hA000 + 16'(i));
    run_base = run_cnt; fin_base = fin_cnt;
    start_prog(5'd20);
    for (int i = 0; i < 16; i++) exec_instr(16'hA000 + 16'(i), 1, 4'(i), 0);
    chk("p16_fin", bus.Finished, 1);
    chk("p16_pc",  bus.PC, 15);
    step();
    chk("p16_runs", run_cnt - run_base, 16);
    chk("p16_fins", fin_cnt - fin_base, 1);

    // Stop during instruction 1 ends the program after it
    run_base = run_cnt; fin_base = fin_cnt;
    start_prog(5'd5);
    exec_instr(16'hA000, 1, 4'd0, 0);
    exec_instr(16'hA001, 3, 4'd1, 1);
    chk("stop_fin",  bus.Finished, 1);
    chk("stop_busy", bus.Busy, 0);
    chk("stop_pc",   bus.PC, 1);
    step(); step();
    chk("stop_runs", run_cnt - run_base, 2);
    chk("stop_fins", fin_cnt - fin_base, 1);

    // Zero length: no issue, Finished pulse only
    run_base = run_cnt;
    start_prog(5'd0);
    chk("zero_fin",  bus.Finished, 1);
    chk("zero_busy", bus.Busy, 0);
    step();
    chk("zero_fin_pulse", bus.Finished, 0);
    chk("zero_runs", run_cnt - run_base, 0);

    // Watchdog: no Done for 8 WAIT cycles
    run_base = run_cnt;
    start_prog(5'd1);
    chk("to_issue", bus.Run, 1);
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_pending", bus.Timeout, 0);
    end
    step();
    chk("to_flag", bus.Timeout, 1);
    chk("to_busy", bus.Busy, 0);
    chk("to_din",  bus.DIN, 0);
    step();
    chk("to_sticky", bus.Timeout, 1);
    chk("to_runs", run_cnt - run_base, 1);
    start_prog(5'd1);
    chk("to_clear", bus.Timeout, 0);
    chk("to_noissue", bus.Run, 0);
    step();
    chk("to_idle_run", bus.Run, 0);
    chk("to_idle_busy", bus.Busy, 0);

    // Done on the 8th WAIT cycle beats the watchdog
    start_prog(5'd1);
    exec_instr(16'hA000, 8, 4'd0, 0);
    chk("race_fin", bus.Finished, 1);
    chk("race_tmo", bus.Timeout, 0);
    step();

    // Reset in WAIT of instruction 1 abandons it silently
    fin_base = fin_cnt;
    start_prog(5'd3);
    exec_instr(16'hA000, 1, 4'd0, 0);
    step();
    #2;
    Resetn = 1'b0;
    #1;
    chk("arst_busy", bus.Busy, 0);
    chk("arst_run",  bus.Run, 0);
    chk("arst_din",  bus.DIN, 0);
    chk("arst_pc",   bus.PC, 0);
    chk("arst_tmo",  bus.Timeout, 0);
    step();
    Resetn = 1'b1;
    step(); step();
    chk("arst_nofin", fin_cnt - fin_base, 0);
    start_prog(5'd3);
    exec_instr(16'hA000, 1, 4'd0, 0);
    exec_instr(16'hA001, 1, 4'd1, 0);
    exec_instr(16'hA002, 1, 4'd2, 0);
    chk("arst_rerun_fin", bus.Finished, 1);
    step();

    // Write and Start while busy are both ignored
    run_base = run_cnt;
    start_prog(5'd2);
    chk("busy_issue_din", bus.DIN, 16'hA000);
    step();
    bus.WrEn = 1'b1; bus.WrAddr = 4'd0; bus.WrData = 16'hFFFF; bus.Start = 1'b1;
    step();
    bus.WrEn = 1'b0; bus.Start = 1'b0;
    chk("busy_run",  bus.Run, 0);
    chk("busy_pc",   bus.PC, 0);
    chk("busy_din",  bus.DIN, 16'hA000);
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    exec_instr(16'hA001, 1, 4'd1, 0);
    chk("busy_fin", bus.Finished, 1);
    step();
    chk("busy_runs", run_cnt - run_base, 2);
    start_prog(5'd1);
    exec_instr(16'hA000, 1, 4'd0, 0);
    chk("busy_mem0_fin", bus.Finished, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
